// File: rtl/pipo_piso_sipo_if.sv
// Bus bundle for the three-channel shift/parallel register block.
// The testbench drives through the master modport; the register block uses slave.
interface pipo_piso_sipo_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] piso_din;
    logic             piso_pl;
    logic             piso_so;
    logic             piso_dout;

    logic             sipo_din;
    logic             sipo_sl;
    logic             sipo_po;
    logic [WIDTH-1:0] sipo_dout;

    logic [WIDTH-1:0] pipo_din;
    logic             pipo_pl;
    logic             pipo_po;
    logic [WIDTH-1:0] pipo_dout;

    modport master (
        output piso_din, piso_pl, piso_so,
        output sipo_din, sipo_sl, sipo_po,
        output pipo_din, pipo_pl, pipo_po,
        input  piso_dout, sipo_dout, pipo_dout
    );

    modport slave (
        input  piso_din, piso_pl, piso_so,
        input  sipo_din, sipo_sl, sipo_po,
        input  pipo_din, pipo_pl, pipo_po,
        output piso_dout, sipo_dout, pipo_dout
    );
endinterface

// File: rtl/pipo_piso_sipo.sv
// Three independent WIDTH-bit registers (PISO, SIPO, PIPO) sharing clk and rst.
// Output enables gate the register contents combinationally; disabled outputs read 0.
module pipo_piso_sipo #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipo_piso_sipo_if.slave    bus
);

    logic [WIDTH-1:0] piso_q;
    logic [WIDTH-1:0] piso_d;
    logic [WIDTH-1:0] sipo_q;
    logic [WIDTH-1:0] sipo_d;
    logic [WIDTH-1:0] pipo_q;
    logic [WIDTH-1:0] pipo_d;

    // PISO shifts right toward bit 0 with zero fill, so words leave LSB first.
    always_comb begin
        piso_d = piso_q;
        if (bus.piso_pl) begin
            piso_d = bus.piso_din;
        end else begin
            piso_d = {1'b0, piso_q[WIDTH-1:1]};
        end
    end

    // SIPO takes new bits at the MSB so an LSB-first stream lands in order.
    always_comb begin
        sipo_d = sipo_q;
        if (bus.sipo_sl) begin
            sipo_d = {bus.sipo_din, sipo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        pipo_d = pipo_q;
        if (bus.pipo_pl) begin
            pipo_d = bus.pipo_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piso_q <= '0;
            sipo_q <= '0;
            pipo_q <= '0;
        end else begin
            piso_q <= piso_d;
            sipo_q <= sipo_d;
            pipo_q <= pipo_d;
        end
    end

    assign bus.piso_dout = bus.piso_so & piso_q[0];
    assign bus.sipo_dout = bus.sipo_po ? sipo_q : '0;
    assign bus.pipo_dout = bus.pipo_po ? pipo_q : '0;

endmodule

// File: tb/tb_pipo_piso_sipo.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
// The model tracks a loaded word plus shift count, a bit-history window and a held word.
module tb_pipo_piso_sipo;
    localparam int W = 4;

    logic clk;
    logic rst;

    pipo_piso_sipo_if #(.WIDTH(W)) bus ();

    pipo_piso_sipo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         piso;
        logic [W-1:0] sipo;
        logic [W-1:0] pipo;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int unsigned m_piso_word;
    int          m_piso_shifts;
    bit          m_sipo_hist[$];
    int unsigned m_pipo_word;

    task automatic model_reset();
        m_piso_word   = 0;
        m_piso_shifts = W;
        m_sipo_hist.delete();
        for (int i = 0; i < W; i++) m_sipo_hist.push_back(1'b0);
        m_pipo_word   = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (bus.piso_pl) begin
                m_piso_word   = int'(bus.piso_din);
                m_piso_shifts = 0;
            end else if (m_piso_shifts < W) begin
                m_piso_shifts++;
            end
            if (bus.sipo_sl) begin
                m_sipo_hist.push_back(bus.sipo_din);
                void'(m_sipo_hist.pop_front());
            end
            if (bus.pipo_pl) m_pipo_word = int'(bus.pipo_din);
        end
    endtask

    function automatic exp_t predict(string tag);
        exp_t e;
        logic [W-1:0] v;
        int unsigned bitv;
        bitv = (m_piso_shifts < W) ? ((m_piso_word >> m_piso_shifts) & 1) : 0;
        e.piso = bus.piso_so && (bitv != 0);
        // oldest bit in the window sits at bit 0, newest at the MSB
        v = '0;
        for (int i = 0; i < W; i++) v[i] = m_sipo_hist[i];
        e.sipo = bus.sipo_po ? v : '0;
        e.pipo = bus.pipo_po ? W'(m_pipo_word) : '0;
        e.tag  = tag;
        return e;
    endfunction

    task automatic step(input logic r,
                        input logic [W-1:0] pdin, input logic ppl, input logic pso,
                        input logic sdin, input logic ssl, input logic spo,
                        input logic [W-1:0] qdin, input logic qpl, input logic qpo,
                        input string tag);
        @(posedge clk);
        model_edge();
        #1;
        rst          = r;
        bus.piso_din = pdin;
        bus.piso_pl  = ppl;
        bus.piso_so  = pso;
        bus.sipo_din = sdin;
        bus.sipo_sl  = ssl;
        bus.sipo_po  = spo;
        bus.pipo_din = qdin;
        bus.pipo_pl  = qpl;
        bus.pipo_po  = qpo;
        if (r) model_reset();
        exp_q.push_back(predict(tag));
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.piso_dout !== e.piso) begin
                    bad++;
                    $display("FAIL piso_dout[%s] got=%b want=%b", e.tag, bus.piso_dout, e.piso);
                end
                total++;
                if (bus.sipo_dout !== e.sipo) begin
                    bad++;
                    $display("FAIL sipo_dout[%s] got=%b want=%b", e.tag, bus.sipo_dout, e.sipo);
                end
                total++;
                if (bus.pipo_dout !== e.pipo) begin
                    bad++;
                    $display("FAIL pipo_dout[%s] got=%b want=%b", e.tag, bus.pipo_dout, e.pipo);
                end
                $display("txn %s piso=%b sipo=%b pipo=%b", e.tag, bus.piso_dout, bus.sipo_dout, bus.pipo_dout);
            end
        end
    end

    initial begin
        int sbits[4];
        int waits;
        sbits = '{1, 1, 0, 1};
        rst          = 1'b1;
        bus.piso_din = '0; bus.piso_pl = 1'b0; bus.piso_so = 1'b1;
        bus.sipo_din = 1'b0; bus.sipo_sl = 1'b0; bus.sipo_po = 1'b1;
        bus.pipo_din = '0; bus.pipo_pl = 1'b0; bus.pipo_po = 1'b1;
        model_reset();

        step(1, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "reset");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "idle");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "idle");

        // PISO: load 1011 then shift out LSB first
        step(0, 4'b1011, 1, 1, 0, 0, 1, 4'b0000, 0, 1, "piso_load");
        for (int k = 0; k < 6; k++)
            step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "piso_shift");

        // SIPO: feed 1,1,0,1 then hold
        for (int k = 0; k < 4; k++)
            step(0, 4'b0000, 0, 1, sbits[k][0], 1, 1, 4'b0000, 0, 1, "sipo_shift");
        for (int k = 0; k < 5; k++)
            step(0, 4'b0000, 0, 1, 1'($urandom_range(0, 1)), 0, 1, 4'b0000, 0, 1, "sipo_hold");

        // PIPO: load, hold with cleared data input, toggle enable
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b1011, 1, 1, "pipo_load");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "pipo_hold");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "pipo_hold");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 0, "pipo_off");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "pipo_on");

        // Enables: load everything, disable outputs, then re-enable
        for (int k = 0; k < 4; k++)
            step(0, 4'b1011, 1, 1, sbits[k][0], 1, 1, 4'b1011, 1, 1, "load_all");
        step(0, 4'b1011, 1, 0, 0, 0, 0, 4'b1011, 0, 0, "en_off");
        step(0, 4'b1011, 1, 0, 0, 0, 0, 4'b1011, 0, 0, "en_off");
        step(0, 4'b1011, 1, 1, 0, 0, 1, 4'b1011, 0, 1, "en_on");

        // Async reset between edges, loads during reset ignored
        step(1, 4'b1011, 1, 1, 1, 1, 1, 4'b1011, 1, 1, "rst_async");
        step(1, 4'b1011, 1, 1, 1, 1, 1, 4'b1011, 1, 1, "rst_held");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "post_rst");
        step(0, 4'b0000, 0, 1, 0, 0, 1, 4'b0000, 0, 1, "post_rst");

        // Concurrent random traffic on all channels
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 40) == 0),
                 W'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                 W'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                 "rand");

        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipo_piso_sipo.md
PIPO_PISO_SIPO -- requirements
Module: pipo_piso_sipo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits for all three channels; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port piso_din, input, WIDTH bits: PISO parallel load data.
REQ-005 The block SHALL have port piso_pl, input, 1 bit: PISO parallel load (1 = load, 0 = shift).
REQ-006 The block SHALL have port piso_so, input, 1 bit: PISO serial output enable.
REQ-007 The block SHALL have port piso_dout, output, 1 bit: PISO serial output.
REQ-008 The block SHALL have port sipo_din, input, 1 bit: SIPO serial input.
REQ-009 The block SHALL have port sipo_sl, input, 1 bit: SIPO serial load/shift enable.
REQ-010 The block SHALL have port sipo_po, input, 1 bit: SIPO parallel output enable.
REQ-011 The block SHALL have port sipo_dout, output, WIDTH bits: SIPO parallel output.
REQ-012 The block SHALL have port pipo_din, input, WIDTH bits: PIPO parallel load data.
REQ-013 The block SHALL have port pipo_pl, input, 1 bit: PIPO parallel load enable.
REQ-014 The block SHALL have port pipo_po, input, 1 bit: PIPO parallel output enable.
REQ-015 The block SHALL have port pipo_dout, output, WIDTH bits: PIPO parallel output.

Function
REQ-016 The block SHALL contain three independent WIDTH-bit registers (piso_q, sipo_q, pipo_q); the channels share only clk and rst.
REQ-017 PISO: with piso_pl=1, piso_q SHALL take piso_din at the clock edge.
REQ-018 PISO: with piso_pl=0, piso_q SHALL shift right one bit per edge, with 0 entering the MSB.
REQ-019 PISO: piso_dout SHALL be piso_q[0] when piso_so=1 and 0 otherwise.
REQ-020 PISO: piso_dout SHALL be combinational from the register, so the first serial bit appears right after the load edge.
REQ-021 PISO: data SHALL be serialised LSB first; after WIDTH shifts the register is all zero and piso_dout stays 0.
REQ-022 SIPO: with sipo_sl=1, sipo_q SHALL become {sipo_din, sipo_q[WIDTH-1:1]} at the clock edge, shifting right with new bits entering the MSB.
REQ-023 SIPO: with sipo_sl=0, sipo_q SHALL hold.
REQ-024 SIPO: WIDTH bits fed LSB first SHALL leave sipo_q equal to the original word.
REQ-025 SIPO: sipo_dout SHALL be sipo_q when sipo_po=1 and all zeros otherwise.
REQ-026 PIPO: with pipo_pl=1, pipo_q SHALL take pipo_din at the clock edge.
REQ-027 PIPO: with pipo_pl=0, pipo_q SHALL hold.
REQ-028 PIPO: pipo_dout SHALL be pipo_q when pipo_po=1 and all zeros otherwise.
REQ-029 Every load and shift SHALL have one-cycle latency; output enables SHALL act combinationally and never change register contents.
REQ-030 The block SHALL drive no output with high impedance; disabled outputs are 0.

Reset
REQ-031 rst=1 SHALL clear piso_q, sipo_q and pipo_q to 0 immediately, independent of clk.
REQ-032 Reset SHALL override any load or shift on the same edge.
REQ-033 While rst=1 and after it is released, all outputs SHALL read 0 until the next load or shift.
REQ-034 When rst is asserted mid-shift or mid-load, the operation SHALL be aborted with no partial data retained.
REQ-035 After rst deasserts, the first rising clk edge SHALL perform a normal operation.

Verification
REQ-036 PISO: piso_din=1011, piso_so=1, piso_pl=1 for 1 edge then 0 -> piso_dout = 1, 1, 0, 1 (after the load edge and shifts 1-3), then 0 after shift 4.
REQ-037 SIPO: sipo_sl=1, sipo_po=1, sipo_din = 1, 1, 0, 1 on 4 edges, then sipo_sl=0 -> sipo_dout=1011, held over 4 more edges.
REQ-038 PIPO: pipo_din=1011, pipo_pl=1 for 1 edge, then pipo_pl=0 and pipo_din=0000 -> pipo_dout=1011 held; pipo_po=0 -> 0000, and 1011 returns when pipo_po=1.
REQ-039 Enables: after loading all channels, piso_so=0 and sipo_po=0 -> outputs 0; re-enabling restores the data with contents unchanged.
REQ-040 Async reset: assert rst between clock edges after loading 1011 in every channel -> all outputs 0 before the next edge; a load on the edge while rst=1 is ignored.
REQ-041 Concurrent: all three channels run simultaneously with different data -> each result matches its own channel and is unaffected by the others.
